// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - shared field-element constants and types for the femul datapath
//
// Purpose: common widths, the prime p = 2^255-19 and p-2 (inversion exponent),
// plus element/tag typedefs used by the multiplier arbiter and its tag FIFO.
// Ports: none (package).
package fe_pkg;

  localparam int FE_WIDTH = 255;
  localparam int FE_TAG_W = 2;

  // p = 2^255 - 19: 247 ones followed by 0xED.
  localparam logic [FE_WIDTH-1:0] FE_P           = {{247{1'b1}}, 8'hED};
  localparam logic [FE_WIDTH-1:0] FE_P_MINUS_TWO = {{247{1'b1}}, 8'hEB};

  typedef logic [FE_WIDTH-1:0] fe_t;
  typedef logic [FE_TAG_W-1:0] fe_tag_t;

endpackage

// File: rtl/femul_tag_fifo.sv
// rtl/femul_tag_fifo.sv - in-order requester tag FIFO for in-flight femul operations
//
// Purpose: remembers which requester issued each multiplication so results can
// be routed back in issue order.
// Ports:
//   clock, reset       clock and asynchronous active-high reset
//   push, push_data    enqueue a tag (ignored when full unless popping too)
//   pop                dequeue the head tag (ignored when empty)
//   full, empty        occupancy flags
//   head               tag at the front of the queue
module femul_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  // A pop in the same cycle frees the slot, so push into a full FIFO is allowed then.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/femul_arbiter.sv
// rtl/femul_arbiter.sv - round-robin sharing of one pipelined femul among requesters
//
// Purpose: picks one pending requester per issue slot, registers its operands
// into femul, tags the operation, and routes each result back in issue order.
// Ports:
//   clock, reset              clock and asynchronous active-high reset
//   req_valid/req_a/req_b     per-requester request and packed 255-bit operands
//   req_grant                 one-cycle accept pulse per requester
//   resp_done/resp_out        one-cycle result pulse per requester, shared product bus
//   mul_start/mul_a/mul_b     issue port to femul (operands held until next issue)
//   mul_ready                 femul can accept a start this cycle
//   mul_done/mul_out          result port from femul
//   busy                      operations outstanding or being issued
//   error                     sticky: femul produced a result nobody was waiting for
module femul_arbiter
  import fe_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*FE_WIDTH-1:0]   req_a,
  input  logic [NREQ*FE_WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]            req_grant,
  output logic [NREQ-1:0]            resp_done,
  output logic [FE_WIDTH-1:0]        resp_out,
  output logic                       mul_start,
  output logic [FE_WIDTH-1:0]        mul_a,
  output logic [FE_WIDTH-1:0]        mul_b,
  input  logic                       mul_ready,
  input  logic                       mul_done,
  input  logic [FE_WIDTH-1:0]        mul_out,
  output logic                       busy,
  output logic                       error
);

  fe_tag_t         rr_ptr;
  fe_tag_t         win_idx;
  logic            win_found;
  fe_t             win_a;
  fe_t             win_b;
  logic [NREQ-1:0] win_onehot;
  logic [NREQ-1:0] head_onehot;
  logic            issue;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  fe_tag_t         fifo_head;

  // Scan upward from the requester after the last winner; the first pending
  // one wins. rr_ptr only moves on a grant, so idle cycles keep priority put.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!win_found && req_valid[(int'(rr_ptr) + off) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = fe_tag_t'((int'(rr_ptr) + off) % NREQ);
      end
    end
  end

  assign win_a       = req_a[int'(win_idx)*FE_WIDTH +: FE_WIDTH];
  assign win_b       = req_b[int'(win_idx)*FE_WIDTH +: FE_WIDTH];
  assign win_onehot  = NREQ'(1) << win_idx;
  assign head_onehot = NREQ'(1) << fifo_head;

  // femul lowers mul_ready only one cycle after a start, so the cycle in which
  // mul_start is high must never issue; this also swallows the requester's
  // still-high req_valid during its grant cycle.
  assign issue = win_found && mul_ready && !mul_start && !fifo_full;
  assign pop   = mul_done && !fifo_empty;

  femul_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (FE_TAG_W)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (issue),
    .push_data (win_idx),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr    <= fe_tag_t'(NREQ - 1);
      mul_start <= 1'b0;
      req_grant <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      resp_done <= '0;
      resp_out  <= '0;
      error     <= 1'b0;
    end else begin
      mul_start <= issue;
      req_grant <= issue ? win_onehot : '0;
      if (issue) begin
        mul_a  <= win_a;
        mul_b  <= win_b;
        rr_ptr <= win_idx;
      end

      resp_done <= pop ? head_onehot : '0;
      if (pop) resp_out <= mul_out;

      // A result with no tag waiting (e.g. issued before a reset) is dropped.
      if (mul_done && fifo_empty) error <= 1'b1;
    end
  end

  assign busy = !fifo_empty || mul_start;

endmodule

// File: tb/tb_femul_arbiter.sv
// tb/tb_femul_arbiter.sv - scoreboard bench for femul_arbiter with a k=17 femul model
module tb_femul_arbiter;
  import fe_pkg::*;

  localparam int NREQ = 2;
  localparam int K    = 17;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*FE_WIDTH-1:0] req_a;
  logic [NREQ*FE_WIDTH-1:0] req_b;
  logic [NREQ-1:0]          req_grant;
  logic [NREQ-1:0]          resp_done;
  logic [FE_WIDTH-1:0]      resp_out;
  logic                     mul_start;
  logic [FE_WIDTH-1:0]      mul_a;
  logic [FE_WIDTH-1:0]      mul_b;
  logic                     mul_ready;
  logic                     mul_done;
  logic [FE_WIDTH-1:0]      mul_out;
  logic                     busy;
  logic                     error;

  always #5 clock = ~clock;

  femul_arbiter #(.NREQ(NREQ), .MAX_INFLIGHT(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_grant (req_grant),
    .resp_done (resp_done),
    .resp_out  (resp_out),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ready (mul_ready),
    .mul_done  (mul_done),
    .mul_out   (mul_out),
    .busy      (busy),
    .error     (error)
  );

  function automatic logic [FE_WIDTH-1:0] fmul(input logic [FE_WIDTH-1:0] a, input logic [FE_WIDTH-1:0] b);
    logic [2*FE_WIDTH-1:0] pa, pb, pm, pr;
    pa = {{FE_WIDTH{1'b0}}, a};
    pb = {{FE_WIDTH{1'b0}}, b};
    pm = {{FE_WIDTH{1'b0}}, FE_P};
    pr = (pa * pb) % pm;
    return pr[FE_WIDTH-1:0];
  endfunction

  function automatic logic [FE_WIDTH-1:0] rnd_fe();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r[FE_WIDTH-1:0];
  endfunction

  // femul model: start seen in cycle s -> mul_ready low s+1..s+15, high from s+16;
  // mul_done in cycle s+34 with the product of the operands present at s.
  int                  rdy_cnt = 0;
  logic                ready_force = 1'b0;
  logic                pipe_v [2*K] = '{default: 1'b0};
  logic [FE_WIDTH-1:0] pipe_d [2*K] = '{default: '0};

  always @(posedge clock) begin
    if (mul_start) rdy_cnt <= K - 2;
    else if (rdy_cnt > 0) rdy_cnt <= rdy_cnt - 1;
    pipe_v[0] <= mul_start;
    pipe_d[0] <= mul_start ? fmul(mul_a, mul_b) : '0;
    for (int i = 1; i < 2*K; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign mul_ready = ready_force || (rdy_cnt == 0);
  assign mul_done  = pipe_v[2*K-1];
  assign mul_out   = pipe_d[2*K-1];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [FE_WIDTH-1:0] got, input logic [FE_WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int                  tag;
    logic [FE_WIDTH-1:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   resp_cyc[$];
  int   grant_log[$];
  int   n_start = 0;
  int   n_grant = 0;
  int   n_resp  = 0;
  int   inflight = 0;
  int   max_inflight = 0;

  always @(negedge clock) begin
    if (reset) begin
      inflight = 0;
    end else begin
      if (mul_start) begin
        n_start++;
        inflight++;
      end
      if (mul_start || (req_grant != '0)) begin
        check("grant_onehot", 255'($onehot(req_grant)), 255'd1);
        check("grant_with_start", 255'(mul_start), 255'd1);
      end
      if (req_grant != '0) begin
        n_grant++;
        grant_log.push_back(req_grant[1] ? 1 : 0);
      end
      if (resp_done != '0) begin
        n_resp++;
        inflight--;
        resp_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("resp_unexpected", 255'(resp_done), 255'd0);
        end else begin
          cur = sb.pop_front();
          check("resp_tag", 255'(resp_done), 255'(NREQ'(1) << cur.tag));
          check("resp_val", resp_out, cur.val);
        end
      end
      if (inflight > max_inflight) max_inflight = inflight;
    end
  end

  task automatic set_req(input int i, input logic [FE_WIDTH-1:0] a, input logic [FE_WIDTH-1:0] b);
    req_valid[i] = 1'b1;
    req_a[i*FE_WIDTH +: FE_WIDTH] = a;
    req_b[i*FE_WIDTH +: FE_WIDTH] = b;
  endtask

  task automatic push_exp(input int tag, input logic [FE_WIDTH-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int i, output int gc);
    gc = -1;
    for (int n = 0; n < 300 && gc < 0; n++) begin
      @(negedge clock);
      if (req_grant[i]) gc = cyc;
    end
    if (gc < 0) check("grant_timeout", 255'd0, 255'd1);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || !mul_ready) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) check("drain_timeout", 255'd0, 255'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, g, g0, g1, s0, gr0, r0;
    logic [FE_WIDTH-1:0] a3 [2][4];
    logic [FE_WIDTH-1:0] b3 [2][4];
    int jx [2];
    int reload [2];

    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clock);
    check("rst_mul_start", 255'(mul_start), 255'd0);
    check("rst_req_grant", 255'(req_grant), 255'd0);
    check("rst_resp_done", 255'(resp_done), 255'd0);
    check("rst_resp_out", resp_out, 255'd0);
    check("rst_mul_a", mul_a, 255'd0);
    check("rst_mul_b", mul_b, 255'd0);
    check("rst_busy", 255'(busy), 255'd0);
    check("rst_error", 255'(error), 255'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single request: 3 x 5 from requester 0.
    resp_cyc.delete();
    c0 = cyc;
    set_req(0, 255'd3, 255'd5);
    push_exp(0, 255'd15);
    wait_grant(0, g);
    check("t1_grant_cyc", 255'(g), 255'(c0 + 1));
    check("t1_busy_hi", 255'(busy), 255'd1);
    req_valid[0] = 1'b0;
    drain();
    check("t1_resp_n", 255'(resp_cyc.size()), 255'd1);
    if (resp_cyc.size() >= 1) check("t1_resp_cyc", 255'(resp_cyc[0]), 255'(c0 + 36));
    wait_cyc(c0 + 37);
    check("t1_busy_lo", 255'(busy), 255'd0);

    // Modular operand from requester 1: (p-1)^2 mod p = 1.
    set_req(1, FE_P - 255'd1, FE_P - 255'd1);
    push_exp(1, 255'd1);
    wait_grant(1, g);
    req_valid[1] = 1'b0;
    drain();

    // Both requesters at once; the last winner was 1, so 0 goes first.
    resp_cyc.delete();
    c0 = cyc;
    set_req(0, 255'd7, 255'd9);
    set_req(1, 255'd11, 255'd13);
    push_exp(0, 255'd63);
    push_exp(1, 255'd143);
    wait_grant(0, g0);
    req_valid[0] = 1'b0;
    check("t2_grant0_cyc", 255'(g0), 255'(c0 + 1));
    wait_grant(1, g1);
    req_valid[1] = 1'b0;
    check("t2_grant1_cyc", 255'(g1), 255'(c0 + 18));
    drain();
    check("t2_resp_n", 255'(resp_cyc.size()), 255'd2);
    if (resp_cyc.size() >= 2) begin
      check("t2_resp0_cyc", 255'(resp_cyc[0]), 255'(c0 + 36));
      check("t2_resp1_cyc", 255'(resp_cyc[1]), 255'(c0 + 53));
    end

    // Continuous requests: 4 per requester, reloaded the cycle after each grant.
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 2; i++) begin
        a3[i][j] = rnd_fe();
        b3[i][j] = rnd_fe();
      end
      push_exp(0, fmul(a3[0][j], b3[0][j]));
      push_exp(1, fmul(a3[1][j], b3[1][j]));
    end
    grant_log.delete();
    max_inflight = 0;
    jx[0] = 0; jx[1] = 0;
    reload[0] = 0; reload[1] = 0;
    set_req(0, a3[0][0], b3[0][0]);
    set_req(1, a3[1][0], b3[1][0]);
    for (int n = 0; n < 600 && !(jx[0] == 4 && jx[1] == 4 && reload[0] == 0 && reload[1] == 0); n++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (reload[i] != 0) begin
          reload[i] = 0;
          if (jx[i] < 4) set_req(i, a3[i][jx[i]], b3[i][jx[i]]);
          else req_valid[i] = 1'b0;
        end
        if (req_valid[i] && req_grant[i]) begin
          jx[i]++;
          reload[i] = 1;
        end
      end
    end
    req_valid = '0;
    drain();
    check("t3_grant_n", 255'(grant_log.size()), 255'd8);
    for (int k = 0; k < grant_log.size(); k++) check("t3_grant_order", 255'(grant_log[k]), 255'(k % 2));
    check("t3_occ_max", 255'(max_inflight), 255'd2);

    // mul_ready stuck high, request held through its grant cycle: one issue only.
    ready_force = 1'b1;
    s0  = n_start;
    gr0 = n_grant;
    set_req(0, 255'd21, 255'd2);
    push_exp(0, 255'd42);
    @(negedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clock);
    check("t5_starts", 255'(n_start - s0), 255'd1);
    check("t5_grants", 255'(n_grant - gr0), 255'd1);
    ready_force = 1'b0;
    drain();
    check("t5_err_clean", 255'(error), 255'd0);

    // Reset 5 cycles after an issue; the stale result must be dropped.
    set_req(0, 255'd2, 255'd2);
    wait_grant(0, g);
    req_valid[0] = 1'b0;
    wait_cyc(g + 4);
    r0 = n_resp;
    reset = 1'b1;
    #1;
    check("t6_rst_start", 255'(mul_start), 255'd0);
    check("t6_rst_grant", 255'(req_grant), 255'd0);
    check("t6_rst_mul_a", mul_a, 255'd0);
    check("t6_rst_busy", 255'(busy), 255'd0);
    check("t6_rst_resp_out", resp_out, 255'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(g + 36);
    check("t6_error_set", 255'(error), 255'd1);
    check("t6_no_resp", 255'(n_resp - r0), 255'd0);
    wait_cyc(g + 4 + 2*K + 2);
    set_req(0, 255'd6, 255'd7);
    push_exp(0, 255'd42);
    wait_grant(0, g);
    req_valid[0] = 1'b0;
    drain();
    check("t6_resp_after", 255'(n_resp - r0), 255'd1);
    check("t6_error_sticky", 255'(error), 255'd1);
    check("sb_empty", 255'(sb.size()), 255'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
